// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and types for the dense-layer blocks
package nn_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int FRAC_BITS  = 13;

  typedef enum logic {
    IDLE,
    STREAM
  } reader_state_t;

endpackage

// File: rtl/argmax_update.sv
// rtl/argmax_update.sv - one step of a running signed argmax (strict greater-than)
module argmax_update #(
  parameter int DW   = 32,
  parameter int IDXW = 4
) (
  input  logic [IDXW-1:0] cur_idx,
  input  logic [DW-1:0]   cur_val,
  input  logic [IDXW-1:0] best_idx,
  input  logic [DW-1:0]   best_val,
  input  logic            first,
  output logic [IDXW-1:0] nxt_best_idx,
  output logic [DW-1:0]   nxt_best_val
);

  logic take;

  // Strict compare keeps the lower index on ties.
  assign take         = first || ($signed(cur_val) > $signed(best_val));
  assign nxt_best_idx = take ? cur_idx : best_idx;
  assign nxt_best_val = take ? cur_val : best_val;

endmodule

// File: rtl/layer_output_reader.sv
// rtl/layer_output_reader.sv - snapshot a layer's node outputs, stream them, report argmax
module layer_output_reader
  import nn_pkg::*;
#(
  parameter int NUM_NODES = 10,
  parameter int DW        = DW_DEFAULT,
  parameter int IDXW      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_NODES*DW-1:0] n_in,
  input  logic                    cap_req,
  output logic                    cap_busy,
  output logic                    overrun,
  output logic [DW-1:0]           out_data,
  output logic [IDXW-1:0]         out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [IDXW-1:0]         cls_idx,
  output logic [DW-1:0]           cls_val,
  output logic                    cls_valid
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NODES - 1);

  reader_state_t   state, state_nxt;
  logic [IDXW-1:0] cnt;
  logic [DW-1:0]   nbuf [NUM_NODES];
  logic [IDXW-1:0] best_idx, nxt_best_idx;
  logic [DW-1:0]   best_val, nxt_best_val;
  logic [DW-1:0]   cur_val;
  logic            xfer, last_xfer, accept;

  assign out_valid = (state == STREAM);
  assign cur_val   = nbuf[cnt];
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (cnt == LAST_IDX);
  assign cap_busy  = out_valid;
  assign out_data  = out_valid ? cur_val : '0;
  assign out_idx   = out_valid ? cnt : '0;
  assign out_last  = out_valid && (cnt == LAST_IDX);

  argmax_update #(
    .DW   (DW),
    .IDXW (IDXW)
  ) u_argmax (
    .cur_idx      (cnt),
    .cur_val      (cur_val),
    .best_idx     (best_idx),
    .best_val     (best_val),
    .first        (cnt == '0),
    .nxt_best_idx (nxt_best_idx),
    .nxt_best_val (nxt_best_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A capture lands only when idle or exactly on the final handshake.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cap_req) begin
          accept    = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          if (cap_req) begin
            accept = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      overrun   <= 1'b0;
      cls_idx   <= '0;
      cls_val   <= '0;
      cls_valid <= 1'b0;
      for (int k = 0; k < NUM_NODES; k++) begin
        nbuf[k] <= '0;
      end
    end else begin
      overrun   <= cap_req && !accept;
      cls_valid <= last_xfer;
      if (accept) begin
        for (int k = 0; k < NUM_NODES; k++) begin
          nbuf[k] <= n_in[k*DW +: DW];
        end
      end
      if (accept || last_xfer) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
      if (xfer) begin
        best_idx <= nxt_best_idx;
        best_val <= nxt_best_val;
      end
      // Result includes the final beat, so take it straight from the update.
      if (last_xfer) begin
        cls_idx <= nxt_best_idx;
        cls_val <= nxt_best_val;
      end
    end
  end

endmodule
